dm_store_logger: RTL and testbench

- Downstream consumer of the processor_arm data-memory write port (DM_writeEnable, DM_addr, DM_writeData) plus the bench `dump` strobe.
- Records every committed store in a FIFO, together with a cycle stamp.
- On `dump`, the FIFO is drained through a valid/ready stream to the bench or a trace sink. This lets the bench check store order and values without reading the memory array.

---
 rtl/dm_store_logger.sv | 203 ++++++++++++++++++++
 tb/tb_dm_store_logger.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_logger.sv
// rtl/dm_store_logger.sv - store trace FIFO with cycle stamps and a drain stream
//
// Purpose: records every committed data-memory store {addr, data, stamp} in a
// DEPTH-entry FIFO while capturing. When dump is seen, the FIFO is drained through a
// valid/ready stream. Stores that cannot be recorded are counted as drops.
//
// Ports:
//   CLOCK_50        in   single clock, rising edge
//   reset           in   asynchronous, active-low
//   DM_writeEnable  in   store committed this cycle
//   DM_addr         in   N-bit store address
//   DM_writeData    in   N-bit store data
//   dump            in   level, request drain
//   log_valid       out  entry on log_* is valid
//   log_ready       in   sink accepts the entry
//   log_addr        out  N-bit entry address
//   log_data        out  N-bit entry data
//   log_stamp       out  STAMP_W-bit capture stamp of the entry
//   count           out  entries currently held
//   full            out  count == DEPTH
//   overflow        out  sticky, at least one store dropped
//   drop_cnt        out  dropped stores, saturating at 0xFFFF
//   dump_done       out  drain complete
module dm_store_logger #(
  parameter int N       = 64,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 32
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   DM_writeEnable,
  input  logic [N-1:0]           DM_addr,
  input  logic [N-1:0]           DM_writeData,
  input  logic                   dump,
  output logic                   log_valid,
  input  logic                   log_ready,
  output logic [N-1:0]           log_addr,
  output logic [N-1:0]           log_data,
  output logic [STAMP_W-1:0]     log_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic                   dump_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]      wr_ptr, rd_ptr, rd_sel;
  logic [STAMP_W-1:0] stamp;

  logic [N-1:0]       mem_addr  [DEPTH];
  logic [N-1:0]       mem_data  [DEPTH];
  logic [STAMP_W-1:0] mem_stamp [DEPTH];

  logic do_store, do_drop, do_pop;
  logic load_out, load_bypass;
  logic valid_nxt, done_nxt, clr_ptrs;
  logic drain_last;

  assign full = (count == CW'(DEPTH));

  // Drain ends when nothing was held on entry, or the last entry is being accepted.
  assign drain_last = (count == '0) || (log_valid && log_ready && (count == CW'(1)));

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= CAPTURE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: if (dump)       state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = DONE;
      DONE:    if (!dump)      state_nxt = CAPTURE;
      default:                 state_nxt = CAPTURE;
    endcase
  end

  // Control outputs of the FSM
  always_comb begin
    do_store    = 1'b0;
    do_drop     = 1'b0;
    do_pop      = 1'b0;
    load_out    = 1'b0;
    load_bypass = 1'b0;
    valid_nxt   = log_valid;
    done_nxt    = dump_done;
    clr_ptrs    = 1'b0;
    rd_sel      = rd_ptr;
    case (state)
      CAPTURE: begin
        do_store  = DM_writeEnable && !full;
        do_drop   = DM_writeEnable && full;
        valid_nxt = 1'b0;
        if (dump) begin
          if (count != '0) begin
            load_out  = 1'b1;
            valid_nxt = 1'b1;
          end else if (DM_writeEnable) begin
            // Empty FIFO but a store lands on the dump edge: present it
            // straight from the inputs, the array write is not visible yet.
            load_out    = 1'b1;
            load_bypass = 1'b1;
            valid_nxt   = 1'b1;
          end
        end
      end
      DRAIN: begin
        do_drop = DM_writeEnable;
        do_pop  = log_valid && log_ready;
        if (drain_last) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
        end else if (do_pop) begin
          // Prefetch the following entry so transfers run back to back.
          load_out  = 1'b1;
          rd_sel    = rd_ptr + 1'b1;
          valid_nxt = 1'b1;
        end
      end
      DONE: begin
        do_drop   = DM_writeEnable;
        valid_nxt = 1'b0;
        if (!dump) begin
          done_nxt = 1'b0;
          clr_ptrs = 1'b1;
        end
      end
      default: begin
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Storage array, no reset needed: contents are only read behind count.
  always_ff @(posedge CLOCK_50) begin
    if (do_store) begin
      mem_addr[wr_ptr]  <= DM_addr;
      mem_data[wr_ptr]  <= DM_writeData;
      mem_stamp[wr_ptr] <= stamp;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      stamp     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      log_valid <= 1'b0;
      dump_done <= 1'b0;
      log_addr  <= '0;
      log_data  <= '0;
      log_stamp <= '0;
    end else begin
      stamp     <= stamp + 1'b1;
      count     <= count + CW'(do_store) - CW'(do_pop);
      log_valid <= valid_nxt;
      dump_done <= done_nxt;
      if (clr_ptrs) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_store) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
      if (load_out) begin
        if (load_bypass) begin
          log_addr  <= DM_addr;
          log_data  <= DM_writeData;
          log_stamp <= stamp;
        end else begin
          log_addr  <= mem_addr[rd_sel];
          log_data  <= mem_data[rd_sel];
          log_stamp <= mem_stamp[rd_sel];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_store_logger.sv
// tb/tb_dm_store_logger.sv - self-checking bench for dm_store_logger
module tb_dm_store_logger;
  localparam int N       = 64;
  localparam int DEPTH   = 16;
  localparam int STAMP_W = 32;

  typedef struct packed {
    logic [N-1:0]       a;
    logic [N-1:0]       d;
    logic [STAMP_W-1:0] s;
  } ent_t;

  logic                   CLOCK_50 = 1'b0;
  logic                   reset = 1'b0;
  logic                   DM_writeEnable = 1'b0;
  logic [N-1:0]           DM_addr = '0;
  logic [N-1:0]           DM_writeData = '0;
  logic                   dump = 1'b0;
  logic                   log_valid;
  logic                   log_ready = 1'b0;
  logic [N-1:0]           log_addr;
  logic [N-1:0]           log_data;
  logic [STAMP_W-1:0]     log_stamp;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   overflow;
  logic [15:0]            drop_cnt;
  logic                   dump_done;

  // Reference model: stores held, drops seen, edges since reset release.
  ent_t               exp_q[$];
  int                 exp_drops;
  logic [STAMP_W-1:0] tb_stamp;

  int n_checks = 0;
  int n_fail   = 0;

  dm_store_logger #(.N(N), .DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .DM_writeEnable (DM_writeEnable),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .dump           (dump),
    .log_valid      (log_valid),
    .log_ready      (log_ready),
    .log_addr       (log_addr),
    .log_data       (log_data),
    .log_stamp      (log_stamp),
    .count          (count),
    .full           (full),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .dump_done      (dump_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // One rising edge, then return at the falling edge where outputs are sampled.
  task automatic cycle();
    @(posedge CLOCK_50);
    tb_stamp = tb_stamp + 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b0;
    DM_writeEnable = 1'b0;
    dump = 1'b0;
    log_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    tb_stamp = '0;
    exp_q.delete();
    exp_drops = 0;
  endtask

  task automatic model_store(input logic [N-1:0] a, input logic [N-1:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    e.s = tb_stamp;
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_drops++;
  endtask

  task automatic store(input logic [N-1:0] a, input logic [N-1:0] d);
    DM_writeEnable = 1'b1;
    DM_addr = a;
    DM_writeData = d;
    model_store(a, d);
    cycle();
    DM_writeEnable = 1'b0;
  endtask

  // Enter drain (optionally with a store on the entry edge and one on the
  // first drain edge), run the stream with the chosen ready behaviour,
  // compare every presented entry to the model, then release dump.
  task automatic drain_all(input int ready_pct, input logic [31:0] pat, input bit use_pat,
                           input bit st_entry, input bit st_after,
                           output int vcyc, output int hs, output int ncyc);
    logic rdy;
    dump = 1'b1;
    log_ready = 1'b0;
    if (st_entry) begin
      DM_writeEnable = 1'b1;
      DM_addr = {$urandom, $urandom};
      DM_writeData = {$urandom, $urandom};
      model_store(DM_addr, DM_writeData);
    end
    cycle();
    DM_writeEnable = 1'b0;
    vcyc = 0;
    hs = 0;
    ncyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (dump_done) break;
      ncyc++;
      if (st_after && i == 0) begin
        DM_writeEnable = 1'b1;
        DM_addr = {$urandom, $urandom};
        DM_writeData = {$urandom, $urandom};
        exp_drops++;
      end
      rdy = use_pat ? pat[i % 32] : ($urandom_range(99) < ready_pct);
      n_checks++;
      if (log_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL drain_valid: log_valid=%b expected %b (pending %0d)",
                 log_valid, (exp_q.size() != 0), exp_q.size());
      end
      if (log_valid === 1'b1) begin
        vcyc++;
        if (exp_q.size() != 0) begin
          n_checks++;
          if (log_addr !== exp_q[0].a || log_data !== exp_q[0].d || log_stamp !== exp_q[0].s) begin
            n_fail++;
            $display("FAIL drain_entry: got %h/%h/%0d expected %h/%h/%0d",
                     log_addr, log_data, log_stamp, exp_q[0].a, exp_q[0].d, exp_q[0].s);
          end
          if (rdy) begin
            exp_q.delete(0);
            hs++;
          end
        end
      end
      log_ready = rdy;
      cycle();
      DM_writeEnable = 1'b0;
    end
    log_ready = 1'b0;
    n_checks++;
    if (dump_done !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_done: dump_done=%b expected 1 within bound", dump_done);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_leftover: %0d entries not drained, expected 0", exp_q.size());
    end
    n_checks++;
    if (count !== '0 || log_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_end: count=%0d log_valid=%b expected 0/0", count, log_valid);
    end
    dump = 1'b0;
    cycle();
    n_checks++;
    if (dump_done !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_release: dump_done=%b expected 0", dump_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (log_valid !== 1'b0 || dump_done !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b done=%b full=%b expected 0/0/0", log_valid, dump_done, full);
    end
    n_checks++;
    if (count !== '0 || overflow !== 1'b0 || drop_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_counts: count=%0d ovf=%b drops=%0d expected 0/0/0", count, overflow, drop_cnt);
    end
    n_checks++;
    if (log_addr !== '0 || log_data !== '0 || log_stamp !== '0) begin
      n_fail++;
      $display("FAIL reset_log: %h/%h/%0d expected zeros", log_addr, log_data, log_stamp);
    end
  endtask

  task automatic test_basic();
    int v, h, c;
    do_reset();
    cycle();
    cycle();
    store(64'h0,  64'hA);
    store(64'h8,  64'hB);
    cycle();
    cycle();
    cycle();
    store(64'h10, 64'hC);
    cycle();
    cycle();
    n_checks++;
    if (count !== 5'd3 || tb_stamp !== 32'd10) begin
      n_fail++;
      $display("FAIL basic_count: count=%0d stamp=%0d expected 3/10", count, tb_stamp);
    end
    n_checks++;
    if (exp_q[0].s !== 32'd2 || exp_q[1].s !== 32'd3 || exp_q[2].s !== 32'd7) begin
      n_fail++;
      $display("FAIL basic_stamps: model %0d/%0d/%0d expected 2/3/7", exp_q[0].s, exp_q[1].s, exp_q[2].s);
    end
    drain_all(100, 32'h0, 1'b0, 1'b0, 1'b0, v, h, c);
    n_checks++;
    if (v != 3 || h != 3 || c != 3) begin
      n_fail++;
      $display("FAIL basic_back_to_back: valid=%0d hs=%0d cycles=%0d expected 3/3/3", v, h, c);
    end
  endtask

  task automatic test_backpressure();
    int v, h, c;
    do_reset();
    store({$urandom, $urandom}, {$urandom, $urandom});
    store({$urandom, $urandom}, {$urandom, $urandom});
    drain_all(0, 32'b10100, 1'b1, 1'b0, 1'b0, v, h, c);
    n_checks++;
    if (v != 5 || h != 2 || c != 5) begin
      n_fail++;
      $display("FAIL backpressure: valid=%0d hs=%0d cycles=%0d expected 5/2/5", v, h, c);
    end
  endtask

  task automatic test_overflow();
    int v, h, c;
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) store({$urandom, $urandom}, {$urandom, $urandom});
    n_checks++;
    if (full !== 1'b1 || count !== 5'(DEPTH) || overflow !== 1'b1 || drop_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL overflow: full=%b count=%0d ovf=%b drops=%0d expected 1/%0d/1/3",
               full, count, overflow, drop_cnt, DEPTH);
    end
    drain_all(60, 32'h0, 1'b0, 1'b0, 1'b0, v, h, c);
    n_checks++;
    if (h != DEPTH || overflow !== 1'b1 || drop_cnt !== 16'd3 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_drain: hs=%0d ovf=%b drops=%0d full=%b expected %0d/1/3/0",
               h, overflow, drop_cnt, full, DEPTH);
    end
  endtask

  task automatic test_simul_store_dump();
    int v, h, c;
    do_reset();
    store({$urandom, $urandom}, {$urandom, $urandom});
    store({$urandom, $urandom}, {$urandom, $urandom});
    drain_all(100, 32'h0, 1'b0, 1'b1, 1'b1, v, h, c);
    n_checks++;
    if (h != 3 || drop_cnt !== 16'd1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_store_dump: hs=%0d drops=%0d ovf=%b expected 3/1/1", h, drop_cnt, overflow);
    end
  endtask

  task automatic test_empty_dump();
    int v, h, c;
    do_reset();
    drain_all(100, 32'h0, 1'b0, 1'b0, 1'b0, v, h, c);
    n_checks++;
    if (v != 0 || c != 1) begin
      n_fail++;
      $display("FAIL empty_dump: valid=%0d cycles=%0d expected 0/1", v, c);
    end
    store({$urandom, $urandom}, {$urandom, $urandom});
    store({$urandom, $urandom}, {$urandom, $urandom});
    drain_all(100, 32'h0, 1'b0, 1'b0, 1'b0, v, h, c);
    n_checks++;
    if (h != 2) begin
      n_fail++;
      $display("FAIL empty_then_store: hs=%0d expected 2", h);
    end
    drain_all(100, 32'h0, 1'b0, 1'b1, 1'b0, v, h, c);
    n_checks++;
    if (h != 1 || c != 1) begin
      n_fail++;
      $display("FAIL empty_bypass: hs=%0d cycles=%0d expected 1/1", h, c);
    end
  endtask

  task automatic test_reset_mid_drain();
    int v, h, c;
    do_reset();
    for (int i = 0; i < 5; i++) store({$urandom, $urandom}, {$urandom, $urandom});
    dump = 1'b1;
    log_ready = 1'b0;
    cycle();
    DM_writeEnable = 1'b1;
    cycle();
    DM_writeEnable = 1'b0;
    n_checks++;
    if (log_valid !== 1'b1 || overflow !== 1'b1 || count !== 5'd5) begin
      n_fail++;
      $display("FAIL mid_drain_pre: valid=%b ovf=%b count=%0d expected 1/1/5", log_valid, overflow, count);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (log_valid !== 1'b0 || count !== '0 || overflow !== 1'b0 || drop_cnt !== 16'h0 ||
        dump_done !== 1'b0 || log_addr !== '0 || log_data !== '0 || log_stamp !== '0) begin
      n_fail++;
      $display("FAIL mid_drain_reset: valid=%b count=%0d ovf=%b drops=%0d done=%b log=%h/%h/%0d expected all 0",
               log_valid, count, overflow, drop_cnt, dump_done, log_addr, log_data, log_stamp);
    end
    dump = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    tb_stamp = '0;
    exp_q.delete();
    exp_drops = 0;
    store({$urandom, $urandom}, {$urandom, $urandom});
    drain_all(100, 32'h0, 1'b0, 1'b0, 1'b0, v, h, c);
    n_checks++;
    if (h != 1) begin
      n_fail++;
      $display("FAIL restart_after_reset: hs=%0d expected 1", h);
    end
  endtask

  task automatic test_random();
    int v, h, c, len;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(40, 4);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(99) < 60) store({$urandom, $urandom}, {$urandom, $urandom});
        else cycle();
      end
      n_checks++;
      if (count !== 5'(exp_q.size())) begin
        n_fail++;
        $display("FAIL random_count: count=%0d expected %0d", count, exp_q.size());
      end
      drain_all(50, 32'h0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), v, h, c);
      n_checks++;
      if (drop_cnt !== 16'(exp_drops) || overflow !== (exp_drops > 0)) begin
        n_fail++;
        $display("FAIL random_drops: drops=%0d ovf=%b expected %0d/%b",
                 drop_cnt, overflow, exp_drops, (exp_drops > 0));
      end
    end
  endtask

  initial begin
    tb_stamp = '0;
    exp_drops = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_simul_store_dump();
    test_empty_dump();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
